// File: rtl/fifo_senior_pkg.sv
// Shared types and helpers for fifo_senior: count-width helper and the status decode struct.
// The FIFO_SENIOR_FWFT_EN macro (used by the top) selects first-word-fall-through reads.
package fifo_senior_pkg;

  function automatic int count_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } status_t;

endpackage

// File: rtl/fifo_senior_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset on contents.
// Zero-latency read port; no flow control of its own (the top gates writes).
module fifo_senior_mem #(
  parameter int WIDTH_DATA = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH_DATA-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH_DATA-1:0] rdata
);

  logic [WIDTH_DATA-1:0] mem [1 << DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_senior.sv
// Single-clock FIFO with count, almost flags, sticky errors; 1-cycle registered read, or
// FWFT when FIFO_SENIOR_FWFT_EN is defined. Writes refused while full, reads while empty.
module fifo_senior
  import fifo_senior_pkg::*;
#(
  parameter int WIDTH_DATA = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write,
  input  logic [WIDTH_DATA-1:0] data_in,
  input  logic                  read,
  output logic [WIDTH_DATA-1:0] data_out,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = count_width(DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [WIDTH_DATA-1:0] mem_rdata;
  logic                  wr_acc;
  logic                  rd_acc;
  status_t               st;

  // Flags decode the registered count, so they lag an accepted op by one cycle.
  assign st.empty        = (count == '0);
  assign st.full         = (count == CW'(DEPTH));
  assign st.almost_full  = (count >= CW'(AF_THRESH));
  assign st.almost_empty = (count <= CW'(AE_THRESH));

  assign fifo_count   = count;
  assign fifo_empty   = st.empty;
  assign fifo_full    = st.full;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;

  assign wr_acc = write && !st.full;
  assign rd_acc = read && !st.empty;

  fifo_senior_mem #(
    .WIDTH_DATA(WIDTH_DATA),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk_i (clk_i),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error in the same cycle as clr_err leaves the flag set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (write && st.full)  || (overflow  && !clr_err);
      underflow <= (read  && st.empty) || (underflow && !clr_err);
    end
  end

`ifdef FIFO_SENIOR_FWFT_EN
  assign data_out = st.empty ? '0 : mem_rdata;
  assign rd_valid = !st.empty;
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) data_out <= mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_senior.sv
module tb_fifo_senior;

  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       write;
  logic [7:0] data_in;
  logic       read;
  logic [7:0] data_out;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  fifo_senior #(
    .WIDTH_DATA(8),
    .DEPTH_LOG2(2),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .write        (write),
    .data_in      (data_in),
    .read         (read),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .fifo_count   (fifo_count),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    int         cnt;
    logic [7:0] dout;
    logic       vld;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a plain queue plus sticky error bits.
  logic [7:0] mq[$];
  logic       m_ovf, m_unf, m_vld;
  logic [7:0] m_dout;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int ecnt, input logic [7:0] edout,
                            input logic evld, input logic eovf, input logic eunf,
                            input bit chk_data);
    chk({tag, ".count"}, int'(fifo_count), ecnt);
    chk({tag, ".empty"}, int'(fifo_empty), int'(ecnt == 0));
    chk({tag, ".full"},  int'(fifo_full),  int'(ecnt == DEPTH));
    chk({tag, ".afull"}, int'(almost_full),  int'(ecnt >= AF));
    chk({tag, ".aempty"}, int'(almost_empty), int'(ecnt <= AE));
    chk({tag, ".ovf"},   int'(overflow),  int'(eovf));
    chk({tag, ".unf"},   int'(underflow), int'(eunf));
    if (chk_data) begin
      chk({tag, ".dout"}, int'(data_out), int'(edout));
      chk({tag, ".vld"},  int'(rd_valid), int'(evld));
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    write = w; data_in = d; read = r; clr_err = c;
    @(posedge clk_i);
    #1;
    write = 1'b0; read = 1'b0; clr_err = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0; m_dout = 8'h00;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic mcycle(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
    bit         wacc;
    bit         racc;
    logic [7:0] e_dout;
    logic       e_vld;
    wacc  = w && (mq.size() < DEPTH);
    racc  = r && (mq.size() > 0);
    m_ovf = (w && mq.size() == DEPTH) || (m_ovf && !c);
    m_unf = (r && mq.size() == 0)     || (m_unf && !c);
    if (racc) begin
      m_dout = mq.pop_front();
      m_vld  = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    if (wacc) mq.push_back(d);
    drive(w, d, r, c);
`ifdef FIFO_SENIOR_FWFT_EN
    e_vld  = mq.size() > 0;
    e_dout = e_vld ? mq[0] : 8'h00;
`else
    e_vld  = m_vld;
    e_dout = m_dout;
`endif
    check_outs(tag, mq.size(), e_dout, e_vld, m_ovf, m_unf, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; write = 1'b0; read = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    model_reset();
    #12;
    check_outs("reset", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Directed table for the registered-read build's data path; counts and flags hold in both.
    vecs.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h22, 1'b0, 1'b0, 2, 8'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h33, 1'b0, 1'b0, 3, 8'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h44, 1'b0, 1'b0, 4, 8'h00, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3, 8'h11, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h22, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h33, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h44, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 1, 8'h44, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h02, 1'b0, 1'b0, 2, 8'h44, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 3, 8'h44, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h04, 1'b0, 1'b0, 4, 8'h44, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h55, 1'b1, 1'b0, 3, 8'h01, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 3, 8'h01, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h02, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h03, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h04, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 1, 8'h04, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'hA5, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'hA5, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'hA5, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
`ifdef FIFO_SENIOR_FWFT_EN
      check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].vld,
                 vecs[i].ovf, vecs[i].unf, 1'b0);
`else
      check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].vld,
                 vecs[i].ovf, vecs[i].unf, 1'b1);
`endif
    end

    // Pointer wrap with sustained read+write at count 2.
    do_reset();
    mcycle("wrap_fill0", 1'b1, 8'($urandom), 1'b0, 1'b0);
    mcycle("wrap_fill1", 1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      mcycle($sformatf("wrap%0d", i), 1'b1, 8'($urandom), 1'b1, 1'b0);
      chk($sformatf("wrap%0d.hold2", i), int'(fifo_count), 2);
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      mcycle($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 8'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset in the middle of a burst.
    write = 1'b1; read = 1'b1; data_in = 8'h9C;
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check_outs("async_rst", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    write = 1'b0; read = 1'b0;
    @(posedge clk_i);
    #1;
    check_outs("async_rst_hold", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_i = 1'b0;
    model_reset();

    // First word after reset: FWFT shows it next cycle, registered mode needs a read.
    drive(1'b1, 8'h7E, 1'b0, 1'b0);
`ifdef FIFO_SENIOR_FWFT_EN
    check_outs("first_word", 1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_outs("first_pop", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    check_outs("first_word", 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check_outs("first_pop", 0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
